// File: rtl/note_hit_judge.sv
// Judges debounced lane presses against note arrival ticks for the rhythm game.
// Each lane keeps a FIFO of arrival timestamps; outputs are registered pulses plus score/combo.
module note_hit_judge #(
    parameter int TRAVEL_TICKS = 490,
    parameter int WINDOW       = 20,
    parameter int PERFECT      = 6,
    parameter int DEPTH        = 8,
    parameter int TS_W         = 12
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic        clear,
    input  logic        note_valid,
    input  logic [2:0]  note_lanes,
    input  logic [2:0]  btn,
    output logic [2:0]  hit_pulse,
    output logic [2:0]  perfect_pulse,
    output logic [2:0]  miss_pulse,
    output logic [2:0]  stray_pulse,
    output logic [15:0] score,
    output logic [7:0]  combo,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]              PTR_ONE  = (AW+1)'(1);
    localparam logic [TS_W-1:0]          TRAVEL_C = TS_W'(TRAVEL_TICKS);
    localparam logic signed [TS_W-1:0]   WIN_HI   = TS_W'(WINDOW);
    localparam logic signed [TS_W-1:0]   WIN_LO   = TS_W'(-WINDOW);
    localparam logic signed [TS_W-1:0]   PERF_HI  = TS_W'(PERFECT);
    localparam logic signed [TS_W-1:0]   PERF_LO  = TS_W'(-PERFECT);

    function automatic logic [1:0] count3(input logic [2:0] v);
        count3 = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    logic [TS_W-1:0] now_r;
    logic [2:0]      hit_s;
    logic [2:0]      perfect_s;
    logic [2:0]      miss_s;
    logic [2:0]      stray_s;
    logic [2:0]      drop_s;

    // Free-running tick timestamp; clear deliberately leaves it running.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            now_r <= {TS_W{1'b0}};
        end else if (tick) begin
            now_r <= now_r + TS_W'(1);
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_lane
        logic [TS_W-1:0]        mem_r [DEPTH];
        logic [AW:0]            rd_ptr_r;
        logic [AW:0]            wr_ptr_r;
        logic                   empty_s;
        logic                   full_s;
        logic signed [TS_W-1:0] d_s;
        logic                   miss_l_s;
        logic                   in_win_s;
        logic                   hit_l_s;
        logic                   pop_s;
        logic                   spawn_s;
        logic                   push_s;

        assign empty_s  = (rd_ptr_r == wr_ptr_r);
        assign full_s   = (rd_ptr_r[AW] != wr_ptr_r[AW]) &&
                          (rd_ptr_r[AW-1:0] == wr_ptr_r[AW-1:0]);
        // Signed distance is unambiguous because travel plus window stays below half the range.
        assign d_s      = now_r - mem_r[rd_ptr_r[AW-1:0]];
        assign miss_l_s = !empty_s && (d_s > WIN_HI);
        assign in_win_s = !empty_s && !miss_l_s && (d_s >= WIN_LO);
        assign hit_l_s  = btn[i] && in_win_s;
        assign pop_s    = miss_l_s || hit_l_s;
        assign spawn_s  = !clear && note_valid && note_lanes[i];
        assign push_s   = spawn_s && (!full_s || pop_s);

        assign miss_s[i]    = miss_l_s;
        assign hit_s[i]     = hit_l_s;
        assign perfect_s[i] = hit_l_s && (d_s >= PERF_LO) && (d_s <= PERF_HI);
        assign stray_s[i]   = btn[i] && !hit_l_s;
        assign drop_s[i]    = spawn_s && full_s && !pop_s;

        // Arrival storage; a full FIFO popping this cycle overwrites the slot being retired.
        always_ff @(posedge clk) begin
            if (push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= now_r + TRAVEL_C;
            end
        end

        // FIFO pointers carry an extra wrap bit to tell full from empty.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rd_ptr_r <= {(AW+1){1'b0}};
                wr_ptr_r <= {(AW+1){1'b0}};
            end else if (clear) begin
                rd_ptr_r <= {(AW+1){1'b0}};
                wr_ptr_r <= {(AW+1){1'b0}};
            end else begin
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
            end
        end
    end

    logic [1:0]  hits_s;
    logic [2:0]  add_s;
    logic [16:0] score_sum_s;
    logic [8:0]  combo_sum_s;
    logic [15:0] score_nxt_s;
    logic [7:0]  combo_nxt_s;

    assign hits_s      = count3(hit_s);
    assign add_s       = {1'b0, hits_s} + {1'b0, count3(perfect_s)};
    assign score_sum_s = {1'b0, score} + {14'd0, add_s};
    assign combo_sum_s = {1'b0, combo} + {7'd0, hits_s};

    // Saturating score and combo; any miss this cycle discards the cycle's hits from combo.
    always_comb begin
        score_nxt_s = score;
        combo_nxt_s = combo;
        if (score_sum_s[16]) begin
            score_nxt_s = 16'hFFFF;
        end else begin
            score_nxt_s = score_sum_s[15:0];
        end
        if (|miss_s) begin
            combo_nxt_s = 8'd0;
        end else if (combo_sum_s[8]) begin
            combo_nxt_s = 8'hFF;
        end else begin
            combo_nxt_s = combo_sum_s[7:0];
        end
    end

    // Registered judgement outputs; clear zeroes everything and masks the cycle's pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_pulse     <= 3'b000;
            perfect_pulse <= 3'b000;
            miss_pulse    <= 3'b000;
            stray_pulse   <= 3'b000;
            score         <= 16'd0;
            combo         <= 8'd0;
            overflow      <= 1'b0;
        end else if (clear) begin
            hit_pulse     <= 3'b000;
            perfect_pulse <= 3'b000;
            miss_pulse    <= 3'b000;
            stray_pulse   <= 3'b000;
            score         <= 16'd0;
            combo         <= 8'd0;
            overflow      <= 1'b0;
        end else begin
            hit_pulse     <= hit_s;
            perfect_pulse <= perfect_s;
            miss_pulse    <= miss_s;
            stray_pulse   <= stray_s;
            score         <= score_nxt_s;
            combo         <= combo_nxt_s;
            if (|drop_s) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_note_hit_judge.sv
// Directed self-checking bench for note_hit_judge with hand-computed tick timing.
module tb_note_hit_judge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        tick;
    logic        clear;
    logic        note_valid;
    logic [2:0]  note_lanes;
    logic [2:0]  btn;
    logic [2:0]  hit_pulse;
    logic [2:0]  perfect_pulse;
    logic [2:0]  miss_pulse;
    logic [2:0]  stray_pulse;
    logic [15:0] score;
    logic [7:0]  combo;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;
    int now_m    = 0;
    int s;
    logic any_r;

    always #5 clk = ~clk;

    note_hit_judge dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .tick          (tick),
        .clear         (clear),
        .note_valid    (note_valid),
        .note_lanes    (note_lanes),
        .btn           (btn),
        .hit_pulse     (hit_pulse),
        .perfect_pulse (perfect_pulse),
        .miss_pulse    (miss_pulse),
        .stray_pulse   (stray_pulse),
        .score         (score),
        .combo         (combo),
        .overflow      (overflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; the timestamp model advances when tick is seen at an out-of-reset edge.
    task automatic step();
        @(posedge clk);
        if (reset_n && tick) now_m = (now_m + 1) & 32'hFFF;
        #1;
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while (now_m != target && guard < 5000) begin
            step();
            guard++;
        end
        check_eq("run_to", now_m, target);
    endtask

    task automatic spawn(input logic [2:0] lanes);
        note_valid = 1'b1;
        note_lanes = lanes;
        step();
        note_valid = 1'b0;
        note_lanes = 3'b000;
    endtask

    task automatic press(input logic [2:0] b);
        btn = b;
        step();
        btn = 3'b000;
    endtask

    function automatic int arrival(input int at);
        return (at + 490) & 32'hFFF;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; tick = 1'b1; clear = 1'b0;
        note_valid = 1'b0; note_lanes = 3'b000; btn = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        check_eq("reset_pulses", {hit_pulse, perfect_pulse, miss_pulse, stray_pulse}, 12'h000);
        check_eq("reset_score", score, 16'd0);
        check_eq("reset_combo", combo, 8'd0);
        check_eq("reset_ovf", overflow, 1'b0);

        // Idle 1000 ticks.
        any_r = 1'b0;
        repeat (1000) begin
            step();
            if ({hit_pulse, perfect_pulse, miss_pulse, stray_pulse} != 12'h000 ||
                score != 16'd0 || combo != 8'd0 || overflow) any_r = 1'b1;
        end
        check_eq("idle_quiet", any_r, 1'b0);

        // Re-reset so the timestamp restarts at 0.
        #2 reset_n = 1'b0;
        now_m = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        // Perfect hit on R.
        spawn(3'b100);
        run_to(490);
        press(3'b100);
        check_eq("p1_hit", hit_pulse, 3'b100);
        check_eq("p1_perf", perfect_pulse, 3'b100);
        check_eq("p1_score", score, 16'd2);
        check_eq("p1_combo", combo, 8'd1);
        step();
        check_eq("p1_pulse_len", hit_pulse, 3'b000);

        // Good (late by 15) hit on R.
        s = now_m;
        spawn(3'b100);
        run_to(arrival(s) + 15);
        press(3'b100);
        check_eq("g_hit", hit_pulse, 3'b100);
        check_eq("g_perf", perfect_pulse, 3'b000);
        check_eq("g_score", score, 16'd3);
        check_eq("g_combo", combo, 8'd2);

        // Miss on G, with ticks paused at d = WINDOW.
        s = now_m;
        spawn(3'b010);
        run_to(arrival(s) + 20);
        check_eq("m_none_d20", miss_pulse, 3'b000);
        tick = 1'b0;
        any_r = 1'b0;
        repeat (5) begin
            step();
            if (miss_pulse != 3'b000) any_r = 1'b1;
        end
        check_eq("m_paused", any_r, 1'b0);
        tick = 1'b1;
        step();
        check_eq("m_none_edge", miss_pulse, 3'b000);
        step();
        check_eq("m_miss", miss_pulse, 3'b010);
        check_eq("m_combo", combo, 8'd0);
        check_eq("m_score", score, 16'd3);
        step();
        press(3'b010);
        check_eq("st_stray", stray_pulse, 3'b010);
        check_eq("st_hit", hit_pulse, 3'b000);
        check_eq("st_score", score, 16'd3);

        // Early press on B is stray and keeps the note.
        s = now_m;
        spawn(3'b001);
        run_to(arrival(s) - 30);
        press(3'b001);
        check_eq("e_stray", stray_pulse, 3'b001);
        check_eq("e_hit", hit_pulse, 3'b000);
        run_to(arrival(s) - 2);
        press(3'b001);
        check_eq("e_hit2", hit_pulse, 3'b001);
        check_eq("e_perf2", perfect_pulse, 3'b001);
        check_eq("e_score", score, 16'd5);
        check_eq("e_combo", combo, 8'd1);

        // Nine spawns into an eight-deep lane.
        s = now_m;
        note_valid = 1'b1; note_lanes = 3'b010;
        repeat (8) step();
        check_eq("o_not_yet", overflow, 1'b0);
        step();
        note_valid = 1'b0; note_lanes = 3'b000;
        check_eq("o_set", overflow, 1'b1);
        run_to(arrival(s));
        for (int k = 0; k < 8; k++) begin
            press(3'b010);
            check_eq("o_hit", {hit_pulse, perfect_pulse}, 6'b010010);
        end
        press(3'b010);
        check_eq("o_ninth_stray", stray_pulse, 3'b010);
        check_eq("o_score", score, 16'd21);
        check_eq("o_combo", combo, 8'd9);

        // All three lanes in one cycle.
        s = now_m;
        spawn(3'b111);
        run_to(arrival(s));
        press(3'b111);
        check_eq("x_hit", hit_pulse, 3'b111);
        check_eq("x_perf", perfect_pulse, 3'b111);
        check_eq("x_score", score, 16'd27);
        check_eq("x_combo", combo, 8'd12);
        check_eq("x_ovf_sticky", overflow, 1'b1);

        // Timestamp wrap.
        run_to(4000);
        spawn(3'b100);
        run_to(394);
        press(3'b100);
        check_eq("w_hit", {hit_pulse, perfect_pulse}, 6'b100100);
        check_eq("w_score", score, 16'd29);
        check_eq("w_combo", combo, 8'd13);

        // Asynchronous reset with a note pending.
        spawn(3'b010);
        repeat (50) step();
        #2 reset_n = 1'b0;
        now_m = 0;
        #1;
        check_eq("ar_score", score, 16'd0);
        check_eq("ar_combo", combo, 8'd0);
        check_eq("ar_ovf", overflow, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        any_r = 1'b0;
        repeat (600) begin
            step();
            if (miss_pulse != 3'b000) any_r = 1'b1;
        end
        check_eq("ar_no_miss", any_r, 1'b0);

        // Clear with pending notes and a set overflow.
        s = now_m;
        spawn(3'b100);
        run_to(arrival(s));
        press(3'b100);
        check_eq("c_pre_score", score, 16'd2);
        note_valid = 1'b1; note_lanes = 3'b001;
        repeat (9) step();
        note_valid = 1'b0; note_lanes = 3'b000;
        check_eq("c_pre_ovf", overflow, 1'b1);
        spawn(3'b111);
        repeat (10) step();
        clear = 1'b1; btn = 3'b111;
        step();
        clear = 1'b0; btn = 3'b000;
        check_eq("c_pulses", {hit_pulse, perfect_pulse, miss_pulse, stray_pulse}, 12'h000);
        check_eq("c_score", score, 16'd0);
        check_eq("c_combo", combo, 8'd0);
        check_eq("c_ovf", overflow, 1'b0);
        any_r = 1'b0;
        repeat (600) begin
            step();
            if (miss_pulse != 3'b000) any_r = 1'b1;
        end
        check_eq("c_no_miss", any_r, 1'b0);
        press(3'b100);
        check_eq("c_empty_stray", stray_pulse, 3'b100);
        check_eq("c_final_score", score, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
